// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
//   Receive-side command decoder. Collects ASCII bytes from the UART receiver
//   into a line buffer, detects CR / LF / CR-LF line terminators, matches the
//   completed line against the command set and hands a 2-bit response id to
//   the transmit sequencer over a valid/ready handshake.
//
//   Parameters:
//     MAX_LEN   line buffer capacity in characters (5..32)
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     rx_data    received byte
//     rx_valid   one-cycle strobe, rx_data valid this cycle
//     cmd_valid  response id available, held until accepted
//     cmd_ready  sequencer accepts the id when cmd_valid && cmd_ready
//     cmd_id     0=START 1=SHELL 2=ERROR 3=PONG
//     busy       high while a report is pending; rx bytes are dropped
//
//   Build option:
//     UART_CMD_CASE_FOLD_EN  when defined, lowercase a..z are stored as A..Z
// ---------------------------------------------------------------------------
module uart_cmd_decoder #(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_id,
  output logic       busy
);

  localparam int         W       = MAX_LEN * 8;
  localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;

  localparam logic [1:0] ID_START = 2'd0;
  localparam logic [1:0] ID_SHELL = 2'd1;
  localparam logic [1:0] ID_ERROR = 2'd2;
  localparam logic [1:0] ID_PONG  = 2'd3;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;

  // Newest character sits in the low byte, so a right-aligned string literal
  // compares directly against the low bits of the buffer.
  localparam logic [31:0] STR_PING  = "PING";
  localparam logic [39:0] STR_START = "START";

  logic [1:0]   state_q, state_d;
  logic [5:0]   len_q, len_d;
  logic [W-1:0] line_q, line_d;
  logic         skip_lf_q, skip_lf_d;
  logic [1:0]   cmd_id_q, cmd_id_d;

  logic [7:0] ch;
  logic       is_term, is_bs, is_print;
  logic [1:0] class_id;

  // Character as it will be stored.
  always_comb begin
    ch = rx_data;
`ifdef UART_CMD_CASE_FOLD_EN
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) ch = rx_data - 8'h20;
`endif
  end

  assign is_term  = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign is_bs    = (rx_data == CH_BS) || (rx_data == CH_DEL);
  assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  // Classification of the line collected so far; the terminator itself is
  // never stored, so this is valid in the terminator cycle.
  always_comb begin
    class_id = ID_ERROR;
    if (len_q == 6'd0)                                  class_id = ID_SHELL;
    else if (len_q == 6'd4 && line_q[31:0] == STR_PING) class_id = ID_PONG;
    else if (len_q == 6'd5 && line_q[39:0] == STR_START) class_id = ID_START;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    line_d    = line_q;
    skip_lf_d = skip_lf_q;
    cmd_id_d  = cmd_id_q;
    case (state_q)
      ST_COLLECT, ST_DISCARD: begin
        if (rx_valid) begin
          if (rx_data == CH_LF && skip_lf_q) begin
            // second half of a CR-LF pair
            skip_lf_d = 1'b0;
          end else if (is_term) begin
            cmd_id_d  = (state_q == ST_DISCARD) ? ID_ERROR : class_id;
            skip_lf_d = (rx_data == CH_CR);
            state_d   = ST_REPORT;
          end else begin
            skip_lf_d = 1'b0;
            if (state_q == ST_COLLECT) begin
              if (is_bs) begin
                if (len_q != 6'd0) begin
                  line_d = {8'h00, line_q[W-1:8]};
                  len_d  = len_q - 6'd1;
                end
              end else if (is_print) begin
                if (len_q < LEN_MAX) begin
                  line_d = {line_q[W-9:0], ch};
                  len_d  = len_q + 6'd1;
                end else begin
                  state_d = ST_DISCARD;
                end
              end
            end
          end
        end
      end
      ST_REPORT: begin
        // rx bytes are dropped here; skip_lf survives so a trailing LF that
        // arrives after the handshake is still swallowed.
        if (cmd_ready) begin
          state_d = ST_COLLECT;
          len_d   = 6'd0;
          line_d  = '0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      len_q     <= 6'd0;
      line_q    <= '0;
      skip_lf_q <= 1'b0;
      cmd_id_q  <= ID_SHELL;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      line_q    <= line_d;
      skip_lf_q <= skip_lf_d;
      cmd_id_q  <= cmd_id_d;
    end
  end

  assign cmd_valid = (state_q == ST_REPORT);
  assign busy      = (state_q == ST_REPORT);
  assign cmd_id    = cmd_id_q;

endmodule
